run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 160 ++++++++++++++++
 tb/tb_run_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run/step/clear controller: synchronizes and debounces front-panel switches, sequences the 4-phase CPU cycle.
// Latency: switch to clean level 2+DEBOUNCE_CYCLES clkX4; state changes only at the phase==3 boundary.
// No backpressure: cpuEnable is a one-cycle strobe. Optional RUN_CONTROLLER_CYCLE_COUNTER_EN builds the cycle counter.
module run_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 8
) (
    input  logic        clkX4,
    input  logic        rst,
    input  logic        sigCH,
    input  logic        sigCP,
    input  logic        sigCE,
    output logic        cpuEnable,
    output logic        cpuRst,
    output logic [1:0]  phase,
    output logic        running,
    output logic [31:0] cycleCount
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        HALT = 2'd1,
        RUN  = 2'd2,
        STEP = 2'd3
    } state_t;

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    // Channel order in the vectors below: 0 = run switch, 1 = step, 2 = clear.
    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] clean;
    logic [2:0] clean_d;
    logic [7:0] db_cnt   [3];
    logic [7:0] db_cnt_d [3];

    assign raw = {sigCE, sigCP, sigCH};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            clean_d[i]  = clean[i];
            db_cnt_d[i] = db_cnt[i];
            if (sync2[i] == clean[i]) begin
                db_cnt_d[i] = 8'd0;
            end else if (db_cnt[i] >= DB_LAST) begin
                clean_d[i]  = sync2[i];
                db_cnt_d[i] = 8'd0;
            end else begin
                db_cnt_d[i] = db_cnt[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clkX4) begin
        if (!rst) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
            clean <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= 8'd0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            clean <= clean_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= db_cnt_d[i];
            end
        end
    end

    state_t     state;
    state_t     state_d;
    logic [7:0] hold_cnt;
    logic       step_pending;
    logic       step_pending_d;
    logic [1:0] phase_d;
    logic       clear_d;
    logic       cp_fall;

    // Outputs are registered from next-cycle values so they line up with the
    // clean levels and the state they describe.
    assign phase_d = phase + 2'd1;
    assign clear_d = ~clean_d[2];
    assign cp_fall = clean[1] & ~clean_d[1];

    always_comb begin
        state_d = state;
        if (phase == 2'd3) begin
            case (state)
                HOLD: if (hold_cnt >= HOLD_LAST) state_d = HALT;
                HALT: begin
                    if (!clean[0]) begin
                        state_d = RUN;
                    end else if (step_pending) begin
                        state_d = STEP;
                    end
                end
                RUN:  if (clean[0]) state_d = HALT;
                STEP: state_d = HALT;
                default: state_d = HALT;
            endcase
        end
        if (clear_d) begin
            state_d = HALT;
        end
    end

    // Leaving HALT for any reason (including run winning over a step) drops the request.
    always_comb begin
        step_pending_d = step_pending;
        if (clear_d || (state == HALT && state_d != HALT)) begin
            step_pending_d = 1'b0;
        end else if (state == HALT && cp_fall) begin
            step_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clkX4) begin
        if (!rst) begin
            phase        <= 2'd0;
            state        <= HOLD;
            hold_cnt     <= 8'd0;
            step_pending <= 1'b0;
            cpuEnable    <= 1'b0;
            cpuRst       <= 1'b0;
            running      <= 1'b0;
        end else begin
            phase        <= phase_d;
            state        <= state_d;
            step_pending <= step_pending_d;
            if (state == HOLD && hold_cnt != 8'hFF) begin
                hold_cnt <= hold_cnt + 8'd1;
            end
            cpuRst    <= !clear_d && (state_d != HOLD);
            cpuEnable <= !clear_d && (phase_d == 2'd3) &&
                         ((state_d == STEP) || (state_d == RUN && !clean_d[0]));
            running   <= (state_d == RUN);
        end
    end

`ifdef RUN_CONTROLLER_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clkX4) begin
        if (!rst || clear_d) begin
            cycle_cnt <= 32'd0;
        end else if (cpuEnable) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign cycleCount = cycle_cnt;
`else
    assign cycleCount = 32'd0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: hold sequence, run, step, debounce, clear and mid-run reset.
module tb_run_controller;

    logic        clkX4 = 1'b0;
    logic        rst   = 1'b0;
    logic        sigCH = 1'b1;
    logic        sigCP = 1'b1;
    logic        sigCE = 1'b1;
    logic        cpuEnable;
    logic        cpuRst;
    logic [1:0]  phase;
    logic        running;
    logic [31:0] cycleCount;

    int n_checks    = 0;
    int n_pass      = 0;
    int total_pulses = 0;
    int bad_pulses  = 0;
    int nz_count    = 0;

    run_controller #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES(8)
    ) dut (
        .clkX4(clkX4),
        .rst(rst),
        .sigCH(sigCH),
        .sigCP(sigCP),
        .sigCE(sigCE),
        .cpuEnable(cpuEnable),
        .cpuRst(cpuRst),
        .phase(phase),
        .running(running),
        .cycleCount(cycleCount)
    );

    always #5 clkX4 = ~clkX4;

    // A legal strobe only ever appears at phase 3 with the CPU out of reset.
    always @(negedge clkX4) begin
        if (cpuEnable === 1'b1) begin
            total_pulses++;
            if (phase !== 2'd3 || cpuRst !== 1'b1) bad_pulses++;
        end
`ifndef RUN_CONTROLLER_CYCLE_COUNTER_EN
        if (cycleCount !== 32'd0) nz_count++;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clkX4);
        #1;
    endtask

    task automatic wait_running(input logic val, input int limit, input string tag);
        int k;
        k = 0;
        while (running !== val && k < limit) begin
            tick(1);
            k++;
        end
        check(tag, 32'(running), 32'(val));
    endtask

    task automatic hold_check(input string tag);
        int         len;
        logic [1:0] last_phase;
        len = 0;
        last_phase = 2'd0;
        while (cpuRst !== 1'b1 && len < 50) begin
            last_phase = phase;
            len++;
            tick(1);
        end
        check({tag, "_len"}, 32'(len), 32'd8);
        check({tag, "_end_phase"}, 32'(last_phase), 32'd3);
    endtask

    initial begin
        int p0;
        int p_clear;
        int k;

        tick(3);
        check("reset_cpuRst", 32'(cpuRst), 32'd0);
        check("reset_cpuEnable", 32'(cpuEnable), 32'd0);
        check("reset_running", 32'(running), 32'd0);
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_cycleCount", cycleCount, 32'd0);

        rst = 1'b1;
        hold_check("hold");
        p0 = total_pulses;
        tick(100);
        check("halt_idle_pulses", 32'(total_pulses - p0), 32'd0);
        check("halt_idle_running", 32'(running), 32'd0);

        sigCH = 1'b0;
        wait_running(1'b1, 16, "run_start");
        p0 = total_pulses;
        tick(280);
        check("run_70_pulses", 32'(total_pulses - p0), 32'd70);
`ifdef RUN_CONTROLLER_CYCLE_COUNTER_EN
        check("run_cycleCount", cycleCount, 32'(total_pulses));
`endif

        p0 = total_pulses;
        sigCP = 1'b0;
        tick(10);
        sigCP = 1'b1;
        tick(30);
        check("run_step_ignored", 32'(total_pulses - p0), 32'd10);

        sigCH = 1'b1;
        wait_running(1'b0, 16, "run_stop");
        p0 = total_pulses;
        tick(40);
        check("halt_quiet", 32'(total_pulses - p0), 32'd0);

        p0 = total_pulses;
        sigCP = 1'b0;
        tick(10);
        sigCP = 1'b1;
        tick(40);
        check("step_one", 32'(total_pulses - p0), 32'd1);

        p0 = total_pulses;
        sigCP = 1'b0;
        tick(6);
        sigCP = 1'b1;
        tick(2);
        sigCP = 1'b0;
        tick(6);
        sigCP = 1'b1;
        tick(50);
        check("step_bounce", 32'(total_pulses - p0), 32'd1);

        p0 = total_pulses;
        sigCP = 1'b0;
        tick(2);
        sigCP = 1'b1;
        tick(30);
        check("glitch_ignored", 32'(total_pulses - p0), 32'd0);

        p0 = total_pulses;
        sigCH = 1'b0;
        sigCP = 1'b0;
        wait_running(1'b1, 20, "run_wins");
        check("run_wins_no_step", 32'(total_pulses - p0), 32'd0);
        sigCP = 1'b1;
        tick(20);

        sigCE = 1'b0;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (cpuRst !== 1'b0 && k < 7);
        p_clear = total_pulses;
        check("clear_cpuRst", 32'(cpuRst), 32'd0);
        check("clear_cpuEnable", 32'(cpuEnable), 32'd0);
        check("clear_running", 32'(running), 32'd0);
        check("clear_cycleCount", cycleCount, 32'd0);
        if (k < 6) tick(6 - k);
        sigCE = 1'b1;
        tick(3);
        check("clear_no_pulse", 32'(total_pulses - p_clear), 32'd0);
        wait_running(1'b1, 20, "clear_resume");
        tick(40);
`ifdef RUN_CONTROLLER_CYCLE_COUNTER_EN
        check("resume_cycleCount", cycleCount, 32'(total_pulses - p_clear));
`endif

        rst = 1'b0;
        tick(2);
        check("midreset_cpuRst", 32'(cpuRst), 32'd0);
        check("midreset_cpuEnable", 32'(cpuEnable), 32'd0);
        check("midreset_running", 32'(running), 32'd0);
        check("midreset_phase", 32'(phase), 32'd0);
        check("midreset_cycleCount", cycleCount, 32'd0);
        p0 = total_pulses;
        rst = 1'b1;
        hold_check("hold2");
        check("hold2_no_pulse", 32'(total_pulses - p0), 32'd0);
        wait_running(1'b1, 20, "rerun");

        check("strobe_alignment", 32'(bad_pulses), 32'd0);
`ifndef RUN_CONTROLLER_CYCLE_COUNTER_EN
        check("cycleCount_tied_zero", 32'(nz_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
